// File: rtl/counter_display_ctrl.sv
// -----------------------------------------------------------------------------
// counter_display_ctrl
//
// Purpose:
//   Control block for an 8-bit counter datapath (adder + register, 9-bit count
//   whose bit 8 is the adder carry). It does four jobs:
//     - Sequences the datapath through run / pause / single-step / clear,
//       driven by pre-debounced one-cycle button pulses.
//     - Divides the board clock down to count_en strobes while running.
//     - Keeps a sticky overflow flag, set when the low byte wraps past 8'hFF.
//     - Time-multiplexes the count onto a 4-digit common-anode 7-segment
//       display.
//
// Parameters:
//   STEP_DIV  system_clock cycles between count_en strobes while running (>=2)
//   SCAN_DIV  system_clock cycles per display digit slot (>=2)
//
// Ports:
//   system_clock  in   1  single clock, all state changes on the rising edge
//   system_reset  in   1  asynchronous, active-low reset
//   btn_run       in   1  one-cycle pulse that toggles run/pause
//   btn_step      in   1  one-cycle pulse, single increment while paused
//   btn_clear     in   1  one-cycle pulse that clears the counter
//   count         in   9  datapath count (bit 8 = adder carry)
//   count_en      out  1  one-cycle advance strobe to the datapath register
//   count_clr     out  1  one-cycle synchronous clear strobe to the datapath
//   running       out  1  high while in RUN
//   an            out  4  digit anodes, active-low, one-hot
//   seg           out  7  cathodes {g,f,e,d,c,b,a}, active-low
//   dp            out  1  decimal point, active-low
// -----------------------------------------------------------------------------
module counter_display_ctrl #(
    parameter int STEP_DIV = 25_000_000,
    parameter int SCAN_DIV = 50_000
) (
    input  logic       system_clock,
    input  logic       system_reset,
    input  logic       btn_run,
    input  logic       btn_step,
    input  logic       btn_clear,
    input  logic [8:0] count,
    output logic       count_en,
    output logic       count_clr,
    output logic       running,
    output logic [3:0] an,
    output logic [6:0] seg,
    output logic       dp
);

    localparam int STEP_W = (STEP_DIV > 2) ? $clog2(STEP_DIV) : 1;
    localparam int SCAN_W = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;

    localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(STEP_DIV - 1);
    localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_DIV - 1);

    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_DASH  = 7'b0111111;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        STEP  = 2'd2,
        CLEAR = 2'd3
    } state_t;

    state_t             state;
    state_t             state_next;

    logic [STEP_W-1:0]  step_cnt;
    logic               run_tick;
    logic               ovf;

    logic [SCAN_W-1:0]  scan_cnt;
    logic [1:0]         scan_idx;

    logic [6:0]         seg_p0;
    logic               dp_p0;
    logic [3:0]         an_p0;

    // Hex digit to active-low segment pattern, bit order {g,f,e,d,c,b,a}.
    function automatic logic [6:0] hex_to_seg(input logic [3:0] value);
        logic [6:0] pattern;
        case (value)
            4'h0:    pattern = 7'b1000000;
            4'h1:    pattern = 7'b1111001;
            4'h2:    pattern = 7'b0100100;
            4'h3:    pattern = 7'b0110000;
            4'h4:    pattern = 7'b0011001;
            4'h5:    pattern = 7'b0010010;
            4'h6:    pattern = 7'b0000010;
            4'h7:    pattern = 7'b1111000;
            4'h8:    pattern = 7'b0000000;
            4'h9:    pattern = 7'b0010000;
            4'hA:    pattern = 7'b0001000;
            4'hB:    pattern = 7'b0000011;
            4'hC:    pattern = 7'b1000110;
            4'hD:    pattern = 7'b0100001;
            4'hE:    pattern = 7'b0000110;
            default: pattern = 7'b0001110;
        endcase
        return pattern;
    endfunction

    // -------------------------------------------------------------------------
    // Control FSM: next-state logic. Coincident buttons resolve as
    // clear > run > step. STEP and CLEAR last one cycle and ignore buttons.
    // -------------------------------------------------------------------------
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (btn_clear) begin
                    state_next = CLEAR;
                end else if (btn_run) begin
                    state_next = RUN;
                end else if (btn_step) begin
                    state_next = STEP;
                end
            end
            RUN: begin
                if (btn_clear) begin
                    state_next = CLEAR;
                end else if (btn_run) begin
                    state_next = IDLE;
                end
            end
            STEP:    state_next = IDLE;
            CLEAR:   state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // A run strobe fires only if we stay in RUN across the edge, so a pause
    // or clear landing on the terminal count swallows that strobe.
    assign run_tick = (state == RUN) && (state_next == RUN) && (step_cnt == STEP_LAST);

    // -------------------------------------------------------------------------
    // Control registers: state, step prescaler, strobes, overflow flag.
    // Strobes are registered from the next-state decode so they line up
    // exactly with the STEP/CLEAR cycle and never glitch.
    // -------------------------------------------------------------------------
    always_ff @(posedge system_clock or negedge system_reset) begin
        if (!system_reset) begin
            state     <= IDLE;
            step_cnt  <= '0;
            count_en  <= 1'b0;
            count_clr <= 1'b0;
            running   <= 1'b0;
            ovf       <= 1'b0;
        end else begin
            state     <= state_next;
            count_en  <= (state_next == STEP) || run_tick;
            count_clr <= (state_next == CLEAR);
            running   <= (state_next == RUN);

            // Outside a continuous RUN stretch the prescaler is held at zero,
            // which covers zeroing on entry, on pause and during CLEAR.
            if ((state != RUN) || (state_next != RUN)) begin
                step_cnt <= '0;
            end else if (step_cnt == STEP_LAST) begin
                step_cnt <= '0;
            end else begin
                step_cnt <= step_cnt + STEP_W'(1);
            end

            // The datapath advances on this same edge; seeing 8'hFF with the
            // strobe high means the low byte is wrapping to 8'h00.
            if (state == CLEAR) begin
                ovf <= 1'b0;
            end else if (count_en && (count[7:0] == 8'hFF)) begin
                ovf <= 1'b1;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Display scan: free-running slot timer and digit index.
    // -------------------------------------------------------------------------
    always_ff @(posedge system_clock or negedge system_reset) begin
        if (!system_reset) begin
            scan_cnt <= '0;
            scan_idx <= 2'd0;
        end else if (scan_cnt == SCAN_LAST) begin
            scan_cnt <= '0;
            scan_idx <= scan_idx + 2'd1;
        end else begin
            scan_cnt <= scan_cnt + SCAN_W'(1);
        end
    end

    // -------------------------------------------------------------------------
    // Display stage p0: digit selection from the current index and count.
    // -------------------------------------------------------------------------
    always_comb begin
        seg_p0 = SEG_BLANK;
        case (scan_idx)
            2'd0:    seg_p0 = hex_to_seg(count[3:0]);
            2'd1:    seg_p0 = hex_to_seg(count[7:4]);
            2'd2:    seg_p0 = hex_to_seg({3'b000, count[8]});
            default: seg_p0 = running ? SEG_DASH : SEG_BLANK;
        endcase
        an_p0 = ~(4'b0001 << scan_idx);
        dp_p0 = ~((scan_idx == 2'd2) && ovf);
    end

    // -------------------------------------------------------------------------
    // Display output registers: anode, cathodes and dp move together so the
    // pattern always matches the lit digit.
    // -------------------------------------------------------------------------
    always_ff @(posedge system_clock or negedge system_reset) begin
        if (!system_reset) begin
            an  <= 4'b1111;
            seg <= SEG_BLANK;
            dp  <= 1'b1;
        end else begin
            an  <= an_p0;
            seg <= seg_p0;
            dp  <= dp_p0;
        end
    end

endmodule
